// File: rtl/nonce_fifo.sv
// Solution FIFO: stores {unit, nonce} records and reads them out bytewise.
// Optional macro NONCE_FIFO_DEDUP_EN drops a repeat of the last accepted push.
module nonce_fifo #(
  parameter int DEPTH  = 4,
  parameter int UNIT_W = 4
) (
  input  logic                     M1_CLK,
  input  logic                     RST_N,
  input  logic                     sol_valid,
  input  logic [31:0]              sol_nonce,
  input  logic [UNIT_W-1:0]        sol_unit,
  input  logic                     rd_byte_strobe,
  input  logic                     rd_clear,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     irq
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_unit  [DEPTH];
  logic [31:0]   mem_nonce [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [2:0]    idx;
  logic          not_empty;
  logic          full;
  logic          pop;
  logic          dup;
  logic          push;
  logic          drop;

  assign not_empty = count != '0;
  assign full      = count == (AW+1)'(DEPTH);
  assign pop       = rd_byte_strobe & not_empty & (idx == 3'd4);
  assign push      = sol_valid & ~dup & (~full | pop);
  assign drop      = sol_valid & ~dup & full & ~pop;

`ifdef NONCE_FIFO_DEDUP_EN
  logic              last_vld;
  logic [UNIT_W+31:0] last;

  assign dup = last_vld && (last == {sol_unit, sol_nonce});

  always_ff @(posedge M1_CLK) begin
    if (!RST_N || rd_clear) begin
      last_vld <= 1'b0;
      last     <= '0;
    end else if (push) begin
      last_vld <= 1'b1;
      last     <= {sol_unit, sol_nonce};
    end
  end
`else
  assign dup = 1'b0;
`endif

  // Storage is not reset; only the pointers and count qualify it.
  always_ff @(posedge M1_CLK) begin
    if (RST_N && !rd_clear && push) begin
      mem_unit[wr_ptr]  <= 8'(sol_unit);
      mem_nonce[wr_ptr] <= sol_nonce;
    end
  end

  always_ff @(posedge M1_CLK) begin
    if (!RST_N) begin
      count    <= '0;
      idx      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      irq      <= 1'b0;
    end else begin
      irq <= not_empty | overflow;
      if (rd_clear) begin
        count    <= '0;
        idx      <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        overflow <= 1'b0;
      end else begin
        if (rd_byte_strobe && not_empty)
          idx <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
        if (pop)
          rd_ptr <= rd_ptr + 1'b1;
        if (push)
          wr_ptr <= wr_ptr + 1'b1;
        if (drop)
          overflow <= 1'b1;
        if (push && !pop)
          count <= count + 1'b1;
        else if (pop && !push)
          count <= count - 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = 8'h00;
    if (not_empty) begin
      unique case (idx)
        3'd0:    rd_data = mem_unit[rd_ptr];
        3'd1:    rd_data = mem_nonce[rd_ptr][7:0];
        3'd2:    rd_data = mem_nonce[rd_ptr][15:8];
        3'd3:    rd_data = mem_nonce[rd_ptr][23:16];
        3'd4:    rd_data = mem_nonce[rd_ptr][31:24];
        default: rd_data = 8'h00;
      endcase
    end
  end

endmodule

// File: doc/nonce_fifo.md
NONCE_FIFO -- requirements
Module: nonce_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of solution entries stored; legal values are 2, 4, 8, 16.
REQ-002 The block SHALL have parameter UNIT_W, default 4, meaning the width of the hash-unit index (1..8).
REQ-003 Port M1_CLK  input  1  the sole clock; all state updates on its rising edge.
REQ-004 Port RST_N  input  1  reset; synchronous and active-low.
REQ-005 Port sol_valid  input  1  single-cycle pulse from a hash unit reporting a winning nonce.
REQ-006 Port sol_nonce  input  32  nonce qualified by sol_valid.
REQ-007 Port sol_unit  input  UNIT_W  index of the reporting hash unit, qualified by sol_valid.
REQ-008 Port rd_byte_strobe  input  1  register-file read strobe; advances the readout by one byte.
REQ-009 Port rd_clear  input  1  single-cycle pulse that flushes all entries and clears overflow.
REQ-010 Port rd_data  output  8  current readout byte of the head entry.
REQ-011 Port count  output  clog2(DEPTH)+1  number of stored entries.
REQ-012 Port overflow  output  1  sticky flag: a solution was dropped.
REQ-013 Port irq  output  1  interrupt request to the register bank.

Function
REQ-014 The block SHALL store each accepted solution as a 5-byte record: byte0 = sol_unit zero-extended to 8 bits, bytes 1..4 = sol_nonce LSB first.
REQ-015 The block SHALL accept a push when sol_valid=1 and (count<DEPTH or a pop completes in the same cycle); the entry SHALL be visible in count on the next cycle.
REQ-016 The block SHALL drop a push when sol_valid=1, count=DEPTH and no pop completes that cycle; it SHALL set overflow to 1 on the next cycle and leave the stored entries unchanged.
REQ-017 The block SHALL keep a byte index 0..4; rd_data SHALL be driven combinationally as byte[index] of the head entry, and SHALL be 8'h00 when count=0.
REQ-018 The block SHALL increment the byte index on rd_byte_strobe=1 when count>0; on rd_byte_strobe=1 with index=4 it SHALL reset the index to 0 and pop the head entry. This is a pop completion.
REQ-019 The block SHALL ignore rd_byte_strobe when count=0: the index stays 0 and count does not underflow.
REQ-020 The block SHALL wrap read and write pointers modulo DEPTH; count SHALL equal (pushes accepted - pops completed).
REQ-021 When a push and a pop completion occur in the same cycle, count SHALL be unchanged and both SHALL take effect.
REQ-022 rd_clear SHALL have priority over push and pop in the same cycle: next cycle count=0, index=0, overflow=0, and the simultaneous push is discarded.
REQ-023 irq SHALL be a registered level equal to (count>0) OR overflow, with one cycle of latency after the state change.

Reset
REQ-024 When RST_N=0 at a rising M1_CLK edge, the block SHALL set count=0, byte index=0, pointers=0, overflow=0 and irq=0; rd_data then reads 8'h00.
REQ-025 A reset asserted mid-record SHALL discard all entries, including the partially read one; sol_valid during reset SHALL be ignored.
REQ-026 Storage contents need not be reset.

Configuration
REQ-027 With macro NONCE_FIFO_DEDUP_EN defined, the block SHALL hold the last accepted {sol_unit, sol_nonce}, reset to invalid by reset and by rd_clear. It SHALL silently discard a push equal to that value: no store, no overflow.
REQ-028 Without NONCE_FIFO_DEDUP_EN, every push SHALL be handled per REQ-015/016, and the block SHALL contain no dedup registers.

Verification
REQ-029 Reset, then push unit=3, nonce=32'hA1B2C3D4 -> count=1, irq=1 one cycle later; five strobes read 03,D4,C3,B2,A1; count=0 and irq=0 one cycle after the last strobe.
REQ-030 Push 5 distinct nonces with DEPTH=4 -> count=4, overflow=1, entries 1..4 read back intact, the 5th entry is absent.
REQ-031 With count=4, apply the 5th strobe of the head record in the same cycle as a push -> count stays 4, overflow stays 0, the new entry is read last.
REQ-032 Apply 3 strobes with count=0 -> rd_data=00, count=0; then push -> the first read byte is byte0.
REQ-033 Mid-record (index=2), assert rd_clear together with sol_valid -> count=0, index=0, overflow=0, irq=0 two cycles later; repeat with RST_N=0 in place of rd_clear -> same result.
REQ-034 With NONCE_FIFO_DEDUP_EN defined, push the same {unit=1, nonce=32'h12345678} twice, then a different nonce -> count=2; after rd_clear, the same value is accepted again -> count=1.
